// File: rtl/apb_req_arbiter_pkg.sv
// apb_req_arbiter_pkg: shared FSM state type and default bus widths for the
// two-requester APB arbiter.
package apb_req_arbiter_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/apb_req_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant. A requester that is alone wins at once;
// when both are eligible, the one that was not granted last wins. Masked
// requests are never eligible.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic [1:0] grant
);

  logic [1:0] eligible;

  assign eligible = req & ~mask;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      localparam logic ME = 1'(gi);
      // Win when eligible and either uncontested or not the last winner.
      assign grant[gi] = eligible[gi] & (~eligible[1-gi] | (last != ME));
    end
  endgenerate

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: arbitrates two request/ack clients onto one APB master
// port with two slave selects (PADDR MSB picks the slave).
// Build option: define APB_ARB_TIMEOUT_EN to abort ACCESS phases that see
// TIMEOUT consecutive cycles of PREADY low; such a transfer is acked with
// err=1 and rdata=0. Without it ACCESS waits on PREADY indefinitely.
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req,
  input  logic [1:0]          wr,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                PSEL1,
  output logic                PSEL2,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR
);

  state_t            state_reg, state_next;
  logic              wr_reg, wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              winner_reg, winner_next;
  logic              last_reg, last_next;
  logic [1:0]        ack_reg, ack_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic [1:0]        grant;
  logic [1:0]        done_ack;
  logic              in_xfer;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // The requester being acked this cycle is masked so it cannot re-win
  // with the request it is still holding from the finished transfer.
  rr_arb2 u_rr_arb2 (
    .req  (req),
    .mask (ack_reg),
    .last (last_reg),
    .grant(grant)
  );

  assign done_ack = winner_reg ? 2'b10 : 2'b01;

  // Next-state, grant latching and completion response.
  always_comb begin
    state_next  = state_reg;
    wr_next     = wr_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    winner_next = winner_reg;
    last_next   = last_reg;
    ack_next    = 2'b00;
    rdata_next  = '0;
    err_next    = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_next    = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (|grant) begin
          winner_next = grant[1];
          last_next   = grant[1];
          wr_next     = wr[grant[1]];
          addr_next   = grant[1] ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
          wdata_next  = grant[1] ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
          state_next  = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_next = IDLE;
          ack_next   = done_ack;
          rdata_next = wr_reg ? '0 : PRDATA;
          err_next   = PSLVERR;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next = IDLE;
          ack_next   = done_ack;
          rdata_next = '0;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and latch registers; reset aborts any transfer without an ack.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_reg  <= IDLE;
      wr_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      winner_reg <= 1'b0;
      last_reg   <= 1'b1;
      ack_reg    <= 2'b00;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      wr_reg     <= wr_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      winner_reg <= winner_next;
      last_reg   <= last_next;
      ack_reg    <= ack_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_reg    <= cnt_next;
`endif
    end
  end

  assign in_xfer = (state_reg == SETUP) || (state_reg == ACCESS);
  assign PSEL1   = in_xfer & ~addr_reg[ADDR_W-1];
  assign PSEL2   = in_xfer &  addr_reg[ADDR_W-1];
  assign PENABLE = (state_reg == ACCESS);
  assign PWRITE  = wr_reg;
  assign PADDR   = addr_reg;
  assign PWDATA  = wdata_reg;
  assign ack     = ack_reg;
  assign rdata   = rdata_reg;
  assign err     = err_reg;

endmodule
